pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_if.sv | 24 ++
 rtl/pc_unit.sv | 86 ++++++++
 tb/tb_pc_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-control bus between the pipeline and the program counter unit:
// redirect requests go in, the fetch address, chip enable and misalign pulse come out.
interface pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              misalign;

  modport master (
    output stall, flush, flush_pc, branch_en, branch_target,
    input  pc, ce, misalign
  );

  modport slave (
    input  stall, flush, flush_pc, branch_en, branch_target,
    output pc, ce, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter unit: OFF/START/RUN sequencing, flush/stall/branch redirects with a
// pending-branch slot. Optional target alignment check enabled by PC_ALIGN_CHECK_EN.
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h00000020)
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    OFF,
    START,
    RUN
  } state_t;

  state_t            state;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;

  logic              take;
  logic              bad;
  logic [ADDR_W-1:0] tgt_sel;
  logic [ADDR_W-1:0] redirect_pc;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);
`endif

  // A pending branch outranks a fresh branch_en; both go through the same alignment filter.
  always_comb begin
    take    = pend_valid | bus.branch_en;
    tgt_sel = pend_valid ? pend_target : bus.branch_target;
    bad     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    bad     = take && ((tgt_sel & STEP_MASK) != '0);
`endif
    redirect_pc = bad ? EXC_VEC : tgt_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OFF;
      bus.ce       <= 1'b0;
      bus.pc       <= RESET_VEC;
      bus.misalign <= 1'b0;
      pend_valid   <= 1'b0;
      pend_target  <= '0;
    end else begin
      bus.misalign <= 1'b0;
      case (state)
        OFF: begin
          state  <= START;
          bus.ce <= 1'b1;
        end
        START, RUN: begin
          state <= RUN;
          // flush beats stall, stall only records branches for later
          if (bus.flush) begin
            bus.pc     <= bus.flush_pc;
            pend_valid <= 1'b0;
          end else if (bus.stall) begin
            if (bus.branch_en) begin
              pend_valid  <= 1'b1;
              pend_target <= bus.branch_target;
            end
          end else if (take) begin
            bus.pc       <= redirect_pc;
            bus.misalign <= bad;
            pend_valid   <= 1'b0;
          end else begin
            bus.pc <= bus.pc + ADDR_W'(STEP);
          end
        end
        default: begin
          state  <= OFF;
          bus.ce <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver feeds directed and random redirects into a
// behavioural model whose predictions are checked by a separate monitor after each edge.
module tb_pc_unit;

  localparam int          STEP      = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] EXC_VEC   = 32'h20;

  logic clk;
  logic rst;

  pc_unit_if #(.ADDR_W(32)) bus ();

  pc_unit #(
    .ADDR_W(32),
    .STEP(STEP),
    .RESET_VEC(RESET_VEC),
    .EXC_VEC(EXC_VEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc[$];
  logic        exp_ce[$];
  logic        exp_mis[$];
  string       exp_tag[$];

  // Reference model: running flag, pc, ce, misalign and a pending-target list.
  bit          m_on;
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_mis;
  logic [31:0] m_pend[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] resolve(input logic [31:0] t);
    m_mis = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    if ((t % STEP) != 0) begin
      m_mis = 1'b1;
      return EXC_VEC;
    end
`endif
    return t;
  endfunction

  function automatic void model_step(input logic r, input logic s, input logic f,
                                     input logic [31:0] fp, input logic be,
                                     input logic [31:0] bt);
    if (r) begin
      m_on  = 0;
      m_pc  = RESET_VEC;
      m_ce  = 1'b0;
      m_mis = 1'b0;
      m_pend.delete();
    end else if (!m_on) begin
      m_on  = 1;
      m_ce  = 1'b1;
      m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (f) begin
        m_pc = fp;
        m_pend.delete();
      end else if (s) begin
        if (be) begin
          m_pend.delete();
          m_pend.push_back(bt);
        end
      end else if (m_pend.size() > 0) begin
        m_pc = resolve(m_pend.pop_front());
      end else if (be) begin
        m_pc = resolve(bt);
      end else begin
        m_pc = m_pc + STEP;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the predicted post-edge outputs.
  task automatic applyStimulus(input string name, input logic r, input logic s, input logic f,
                               input logic [31:0] fp, input logic be, input logic [31:0] bt);
    @(negedge clk);
    rst               = r;
    bus.stall         = s;
    bus.flush         = f;
    bus.flush_pc      = fp;
    bus.branch_en     = be;
    bus.branch_target = bt;
    model_step(r, s, f, fp, be, bt);
    exp_pc.push_back(m_pc);
    exp_ce.push_back(m_ce);
    exp_mis.push_back(m_mis);
    exp_tag.push_back(name);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) applyStimulus(name, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_pc.size() > 0) begin
        string tag;
        tag = exp_tag.pop_front();
        checkOutput({tag, ".pc"}, bus.pc, exp_pc.pop_front());
        checkOutput({tag, ".ce"}, {31'b0, bus.ce}, {31'b0, exp_ce.pop_front()});
        checkOutput({tag, ".misalign"}, {31'b0, bus.misalign}, {31'b0, exp_mis.pop_front()});
      end
    end
  end

  initial begin
    logic        r, s, f, be;
    logic [31:0] fp, bt;

    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.flush_pc      = '0;
    bus.branch_en     = 1'b0;
    bus.branch_target = '0;
    model_step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

    applyStimulus("reset_hold", 1'b1, 1'b0, 1'b1, 32'h700, 1'b1, 32'h800);
    applyStimulus("reset_hold", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

    idle("release", 3);

    applyStimulus("flush10", 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, '0);
    applyStimulus("stall_br", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h80);
    applyStimulus("stall_br", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h80);
    idle("after_stall", 2);

    applyStimulus("stall_br_a", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h120);
    applyStimulus("stall_br_b", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h140);
    applyStimulus("pend_vs_br", 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h900);
    idle("after_pend", 1);

    applyStimulus("stall_br", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h80);
    applyStimulus("flush_all", 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h80);
    idle("after_flush", 2);

    applyStimulus("flush_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    idle("wrap", 1);

    applyStimulus("br_mis", 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h102);
    idle("after_mis", 1);
    applyStimulus("flush_odd", 1'b0, 1'b0, 1'b1, 32'h333, 1'b0, '0);
    idle("after_odd", 1);

    applyStimulus("flush40", 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, '0);
    applyStimulus("stall_pend", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h500);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst.pc", bus.pc, RESET_VEC);
    checkOutput("async_rst.ce", {31'b0, bus.ce}, 32'h0);
    applyStimulus("rst_held", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    applyStimulus("off_ignore", 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h500);
    idle("no_stale_pend", 3);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 30);
      f  = ($urandom_range(0, 99) < 10);
      be = ($urandom_range(0, 99) < 30);
      fp = $urandom();
      bt = $urandom();
      if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
      applyStimulus("random", r, s, f, fp, be, bt);
    end

    @(posedge clk);
    #3;
    checkOutput("drain", 32'(exp_pc.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
